// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file read stage with pending-write scoreboard and output register
module operand_fetch (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ISSUE_VALID,
  output logic        ISSUE_READY,
  input  logic [4:0]  ISSUE_RS,
  input  logic [4:0]  ISSUE_RT,
  input  logic [4:0]  ISSUE_RD,
  input  logic        ISSUE_RD_WE,
  input  logic        REG_WRITE,
  input  logic [4:0]  WRITE_REG,
  input  logic [31:0] WRITE_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RS_DATA,
  output logic [31:0] OUT_RT_DATA,
  output logic [4:0]  OUT_RD,
  output logic        OUT_RD_WE
);

  logic [31:0] regs [32];
  logic [1:0]  pend [32];

  logic [31:0] rs_val, rt_val;
  logic        rs_ok, rt_ok, dest_ok, accept;
  logic [31:0] pend_inc, pend_dec;

  // Entry 0 of both arrays is never written after reset, so it always reads zero.
  always_comb begin
    rs_val = 32'd0;
    rt_val = 32'd0;
    if (ISSUE_RS != 5'd0)
      rs_val = (REG_WRITE && WRITE_REG == ISSUE_RS) ? WRITE_DATA : regs[ISSUE_RS];
    if (ISSUE_RT != 5'd0)
      rt_val = (REG_WRITE && WRITE_REG == ISSUE_RT) ? WRITE_DATA : regs[ISSUE_RT];

    rs_ok = (ISSUE_RS == 5'd0) || (pend[ISSUE_RS] == 2'd0) ||
            (pend[ISSUE_RS] == 2'd1 && REG_WRITE && WRITE_REG == ISSUE_RS);
    rt_ok = (ISSUE_RT == 5'd0) || (pend[ISSUE_RT] == 2'd0) ||
            (pend[ISSUE_RT] == 2'd1 && REG_WRITE && WRITE_REG == ISSUE_RT);
    dest_ok = !ISSUE_RD_WE || (ISSUE_RD == 5'd0) || (pend[ISSUE_RD] != 2'd3);

    ISSUE_READY = rs_ok && rt_ok && dest_ok && (!OUT_VALID || OUT_READY);
    accept      = ISSUE_VALID && ISSUE_READY;

    pend_inc = 32'd0;
    pend_dec = 32'd0;
    for (int r = 1; r < 32; r++) begin
      pend_inc[r] = accept && ISSUE_RD_WE && (ISSUE_RD == 5'(r));
      pend_dec[r] = REG_WRITE && (WRITE_REG == 5'(r)) && (pend[r] != 2'd0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID   <= 1'b0;
      OUT_RS_DATA <= 32'd0;
      OUT_RT_DATA <= 32'd0;
      OUT_RD      <= 5'd0;
      OUT_RD_WE   <= 1'b0;
      for (int r = 0; r < 32; r++) begin
        regs[r] <= 32'd0;
        pend[r] <= 2'd0;
      end
    end else begin
      if (REG_WRITE && WRITE_REG != 5'd0)
        regs[WRITE_REG] <= WRITE_DATA;

      for (int r = 1; r < 32; r++) begin
        if (pend_inc[r] && !pend_dec[r])
          pend[r] <= pend[r] + 2'd1;
        else if (pend_dec[r] && !pend_inc[r])
          pend[r] <= pend[r] - 2'd1;
      end

      if (accept) begin
        OUT_VALID   <= 1'b1;
        OUT_RS_DATA <= rs_val;
        OUT_RT_DATA <= rt_val;
        OUT_RD      <= ISSUE_RD;
        OUT_RD_WE   <= ISSUE_RD_WE && (ISSUE_RD != 5'd0);
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
